// File: rtl/vec_ram_loader_if.sv
// Stream-in, RAM-port and status signals of the vector RAM loader.
// The slave modport is the loader's view; master is the environment's view.
interface vec_ram_loader_if #(
  parameter int DW = 8,
  parameter int AW = 7
);
  logic          start;
  logic [AW:0]   len;
  logic [DW-1:0] exp_sum;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_q;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          err;

  modport master (
    output start, len, exp_sum, in_data, in_valid, rd_q,
    input  in_ready, wr_addr, wr_data, wr_en, rd_addr, busy, done, checksum, err
  );

  modport slave (
    input  start, len, exp_sum, in_data, in_valid, rd_q,
    output in_ready, wr_addr, wr_data, wr_en, rd_addr, busy, done, checksum, err
  );
endinterface

// File: rtl/vec_ram_loader.sv
// Loads a counted word stream into RAM port A, then reads it back over port B
// and compares the modular sum against an expected checksum.
module vec_ram_loader #(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input logic           clk,
  input logic           rst_l,
  vec_ram_loader_if.slave bus
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, FIN} state_t;
  state_t st, nxt;

  logic [AW:0]   len_q, idx, ridx;
  logic [DW-1:0] exp_q, wr_data_q, cs_q;
  logic [AW-1:0] wr_addr_q;
  logic          wr_en_q, err_q, bad_done;
  logic          len_ok, hs;

  assign len_ok = (bus.len <= DEPTH);
  assign hs     = (st == LOAD) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (bus.start && len_ok) nxt = (bus.len == '0) ? FIN : LOAD;
      LOAD:    if (hs && (idx == len_q - 1'b1)) nxt = DRAIN;
      DRAIN:   nxt = VERIFY;
      // one extra cycle beyond the last address lets its read data land
      VERIFY:  if (ridx == len_q) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      len_q     <= '0;
      exp_q     <= '0;
      idx       <= '0;
      ridx      <= '0;
      cs_q      <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      bad_done  <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      bad_done <= 1'b0;
      case (st)
        IDLE: if (bus.start) begin
          if (!len_ok) begin
            err_q    <= 1'b1;
            bad_done <= 1'b1;
          end else begin
            len_q <= bus.len;
            exp_q <= bus.exp_sum;
            idx   <= '0;
            ridx  <= '0;
            cs_q  <= '0;
            err_q <= 1'b0;
          end
        end
        LOAD: if (hs) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= idx[AW-1:0];
          wr_data_q <= bus.in_data;
          idx       <= idx + 1'b1;
        end
        VERIFY: begin
          ridx <= ridx + 1'b1;
          if (ridx != '0) cs_q <= cs_q + bus.rd_q;
        end
        FIN: err_q <= err_q | (cs_q != exp_q);
        default: ;
      endcase
    end
  end

  assign bus.in_ready = (st == LOAD);
  assign bus.busy     = (st != IDLE);
  assign bus.done     = (st == FIN) | bad_done;
  assign bus.rd_addr  = ((st == VERIFY) && (ridx < len_q)) ? ridx[AW-1:0] : '0;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.checksum = cs_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_vec_ram_loader.sv
// Bench for vec_ram_loader: directed table, corner sequences and random loads
// scored against a sum-of-words model, with a behavioural dual-port RAM.
module tb_vec_ram_loader;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int checks = 0;
  int failures = 0;

  vec_ram_loader_if #(.DW(8), .AW(7)) bus ();
  vec_ram_loader #(.DW(8), .AW(7)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem [0:127];
  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    bus.rd_q <= mem[bus.rd_addr];
  end

  logic [6:0] wa_log[$];
  logic [7:0] wd_log[$];
  int         wc_log[$];
  logic [6:0] rd_log[$];
  int done_cnt = 0;
  int cyc_cnt = 0;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst_l) begin
      if (bus.wr_en) begin
        wa_log.push_back(bus.wr_addr);
        wd_log.push_back(bus.wr_data);
        wc_log.push_back(cyc_cnt);
      end
      if (bus.busy && !bus.in_ready && !bus.wr_en && !bus.done) rd_log.push_back(bus.rd_addr);
      if (bus.done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {bus.in_ready, bus.wr_en, 1'(|bus.wr_addr), 1'(|bus.wr_data), 1'(|bus.rd_addr),
               bus.busy, bus.done, 1'(|bus.checksum), bus.err}, 32'h0);
  endtask

  // model state: checksum/err persist across a rejected (oversized) start
  logic [7:0] m_cs = 8'h0;
  logic       m_err = 1'b0;

  task automatic model_op(input int n, input logic [7:0] exs, input logic [7:0] ws[$]);
    int s;
    if (n > 128) begin
      m_err = 1'b1;
    end else begin
      s = 0;
      foreach (ws[k]) s += int'(ws[k]);
      m_cs  = 8'(s);
      m_err = (m_cs != exs);
    end
  endtask

  task automatic run_op(input string tag, input int n, input logic [7:0] exs, input logic [7:0] ws[$],
                        input int gmode, input bit inj, input logic [7:0] ecs, input bit eerr);
    int ne, ptr, cyc, extra, nerr;
    bit seen, injd, alt, v;
    ne = (n <= 128) ? n : 0;
    ptr = 0; cyc = 0; extra = 0; seen = 0; injd = 0; alt = 1;
    wa_log.delete(); wd_log.delete(); wc_log.delete(); rd_log.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'(n); bus.exp_sum = exs;
    @(negedge clk);
    while (!seen && cyc < 2000) begin
      if (bus.done) seen = 1;
      if (inj && !injd && bus.busy && !bus.in_ready && !bus.wr_en && !bus.done) begin
        bus.start = 1'b1; bus.len = 8'd5; bus.exp_sum = 8'hFF; injd = 1;
      end else bus.start = 1'b0;
      if (ptr < ne) begin
        case (gmode)
          0: v = 1'b1;
          1: v = alt;
          default: v = 1'($urandom_range(0, 1));
        endcase
        bus.in_data = ws[ptr];
      end else begin
        v = 1'($urandom_range(0, 1));
        bus.in_data = 8'($urandom);
      end
      bus.in_valid = v;
      if (bus.in_ready) alt = !alt;
      if (v && bus.in_ready) begin
        if (ptr < ne) ptr++;
        else extra++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
    chk({tag, ":done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, ":extra_hs"}, 32'(extra), 32'd0);
    chk({tag, ":wr_count"}, 32'(wa_log.size()), 32'(ne));
    nerr = 0;
    for (int k = 0; k < ne && k < wa_log.size(); k++)
      if (wa_log[k] != 7'(k) || wd_log[k] != ws[k]) nerr++;
    chk({tag, ":wr_seq_errs"}, 32'(nerr), 32'd0);
    if (gmode == 0 && ne > 0) begin
      nerr = 0;
      for (int k = 0; k < wc_log.size(); k++) if (wc_log[k] != wc_log[0] + k) nerr++;
      chk({tag, ":wr_b2b_errs"}, 32'(nerr), 32'd0);
    end
    if (ne > 0) begin
      nerr = 0;
      for (int k = 0; k < ne; k++) if (k >= rd_log.size() || rd_log[k] != 7'(k)) nerr++;
      chk({tag, ":rd_seq_errs"}, 32'(nerr), 32'd0);
    end
    chk({tag, ":checksum"}, 32'(bus.checksum), 32'(ecs));
    chk({tag, ":err"}, 32'(bus.err), 32'(eerr));
    chk({tag, ":idle_busy"}, 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, ":still_idle"}, {31'd0, bus.busy | bus.wr_en | bus.done}, 32'd0);
  endtask

  typedef struct {
    string      tag;
    int         n;
    logic [7:0] exs;
    logic [7:0] base;
    logic [7:0] step;
    int         gmode;
    bit         inj;
    logic [7:0] ecs;
    bit         eerr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] ws[$];
    int n;
    logic [7:0] exs;

    tbl[0] = '{"b2b4",     4,   8'h0A, 8'h01, 8'h01, 0, 1'b0, 8'h0A, 1'b0};
    tbl[1] = '{"gaps3",    3,   8'h66, 8'h11, 8'h11, 1, 1'b0, 8'h66, 1'b0};
    tbl[2] = '{"full128",  128, 8'hC0, 8'h00, 8'h01, 0, 1'b0, 8'hC0, 1'b0};
    tbl[3] = '{"bad_sum",  2,   8'h31, 8'h10, 8'h10, 0, 1'b0, 8'h30, 1'b1};
    tbl[4] = '{"len200",   200, 8'h00, 8'h00, 8'h00, 0, 1'b0, 8'h30, 1'b1};
    tbl[5] = '{"len0",     0,   8'h00, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{"vfy_start",5,   8'h19, 8'h01, 8'h02, 0, 1'b1, 8'h19, 1'b0};

    bus.start = 1'b0; bus.len = '0; bus.exp_sum = '0; bus.in_data = '0; bus.in_valid = 1'b0;
    #3;
    chk_reset_outs("reset_outputs");
    @(negedge clk); @(negedge clk);
    rst_l = 1'b1;

    foreach (tbl[i]) begin
      ws.delete();
      if (tbl[i].n <= 128)
        for (int k = 0; k < tbl[i].n; k++) ws.push_back(8'(int'(tbl[i].base) + int'(tbl[i].step) * k));
      model_op(tbl[i].n, tbl[i].exs, ws);
      run_op(tbl[i].tag, tbl[i].n, tbl[i].exs, ws, tbl[i].gmode, tbl[i].inj, tbl[i].ecs, tbl[i].eerr);
    end

    // asynchronous reset in the middle of a load
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd10; bus.exp_sum = 8'h00; bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midload_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #2 rst_l = 1'b0;
    #1 chk_reset_outs("midload_reset_outputs");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_l = 1'b1;
    m_cs = 8'h0; m_err = 1'b0;
    ws.delete();
    for (int k = 0; k < 6; k++) ws.push_back(8'(k * 7 + 3));
    model_op(6, 8'h00, ws);
    run_op("post_reset", 6, 8'h00, ws, 2, 1'b0, m_cs, m_err);

    for (int r = 0; r < 12; r++) begin
      ws.delete();
      if ($urandom_range(0, 5) == 0) n = $urandom_range(129, 255);
      else n = $urandom_range(0, 128);
      if (n <= 128) for (int k = 0; k < n; k++) ws.push_back(8'($urandom));
      exs = 8'($urandom);
      if ($urandom_range(0, 1) == 1 && n <= 128) begin
        int s = 0;
        foreach (ws[k]) s += int'(ws[k]);
        exs = 8'(s);
      end
      model_op(n, exs, ws);
      run_op($sformatf("rnd%0d", r), n, exs, ws, 2, 1'($urandom_range(0, 1)), m_cs, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_ram_loader.md
VEC_RAM_LOADER -- requirements
Module: vec_ram_loader

Interface
REQ-001 SHALL have parameter DW, default 8, RAM word width.
REQ-002 SHALL have parameter AW, default 7, RAM address width; DEPTH = 2^AW = 128.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_l  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin load; sampled only in IDLE.
REQ-006 SHALL have port len  input  AW+1  word count, sampled with start.
REQ-007 SHALL have port exp_sum  input  DW  expected checksum, sampled with start.
REQ-008 SHALL have port in_data  input  DW  stream data.
REQ-009 SHALL have port in_valid  input  1  stream data valid.
REQ-010 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-011 SHALL have ports wr_addr  output  AW, wr_data  output  DW, wr_en  output  1: RAM port A write.
REQ-012 SHALL have port rd_addr  output  AW  RAM port B read address.
REQ-013 SHALL have port rd_q  input  DW  RAM port B data, valid the cycle after rd_addr is presented.
REQ-014 SHALL have ports busy  output  1, done  output  1, checksum  output  DW, err  output  1.

Function
REQ-015 SHALL implement states IDLE, LOAD, DRAIN, VERIFY, FIN.
REQ-016 IDLE: start with 1 <= len <= DEPTH -> LOAD, clear index, checksum and err; capture len, exp_sum.
REQ-017 IDLE: start with len = 0 -> FIN directly, checksum = 0, err = (exp_sum != 0); no RAM writes.
REQ-018 IDLE: start with len > DEPTH -> stay IDLE, err = 1, done pulses 1 cycle next cycle, no RAM access.
REQ-019 LOAD: in_ready = 1; in_ready SHALL be 0 in every other state.
REQ-020 Handshake = in_valid & in_ready at a rising edge; in_valid low cycles insert no writes and lose no data.
REQ-021 Word k accepted at edge t SHALL produce wr_en = 1, wr_addr = k, wr_data = that word during the cycle following t (registered, 1-cycle latency).
REQ-022 wr_en SHALL be 0 except in the single cycle after each handshake.
REQ-023 After handshake len-1 -> DRAIN for exactly one cycle (final write completes), then VERIFY.
REQ-024 VERIFY: rd_addr steps 0,1,...,len-1, one per cycle, starting first VERIFY cycle; rd_addr held at 0 outside VERIFY.
REQ-025 rd_q for address k SHALL be added to checksum at the edge ending the cycle after rd_addr = k; sum modulo 2^DW.
REQ-026 After the last sample -> FIN; FIN lasts one cycle with done = 1, err |= (checksum != exp_sum), then IDLE.
REQ-027 busy SHALL be 1 in LOAD, DRAIN, VERIFY, FIN; 0 in IDLE.
REQ-028 start while busy SHALL be ignored without effect.
REQ-029 len = DEPTH SHALL write addresses 0..127 with no address wrap or counter overflow (index width AW+1).
REQ-030 checksum and err SHALL hold their final values in IDLE until the next accepted start.

Reset
REQ-031 rst_l low SHALL immediately force IDLE, in_ready = 0, wr_en = 0, wr_addr = 0, wr_data = 0, rd_addr = 0, busy = 0, done = 0, checksum = 0, err = 0.
REQ-032 Reset mid-LOAD or mid-VERIFY SHALL abort the operation; RAM contents are then undefined; no output glitch after release beyond reset values.
REQ-033 First start accepted SHALL be at the first rising edge with rst_l high.

Verification
REQ-034 len=4, exp_sum=0x0A, stream 1,2,3,4 back-to-back -> wr_en 4 consecutive cycles addr 0..3; rd_addr 0..3; done 1 cycle; checksum 0x0A, err 0.
REQ-035 len=3, in_valid toggling 1,0,1,0,1 -> exactly 3 writes at addr 0,1,2 with correct data; no writes on gap cycles.
REQ-036 len=128, data = address, exp_sum=0xC0 -> addr 0..127 written, no wrap; checksum 0xC0 (8128 mod 256), err 0.
REQ-037 len=2, data 0x10,0x20, exp_sum=0x31 -> done with checksum 0x30, err 1; len=200 -> no writes, err 1, done 1 cycle.
REQ-038 start during VERIFY -> ignored; rst_l low mid-LOAD -> all outputs at reset values same cycle, busy 0, next start accepted normally.
REQ-039 len=0, exp_sum=0 -> done next cycle, checksum 0, err 0, no wr_en or handshakes.
